// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: opcodes, ALUOp encodings and the
// control bundle carried from ID into EX.
package rv_pkg;
    localparam int REG_IDX_W = 5;

    localparam logic [6:0] OP_RI   = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BLT  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_NOP  = 7'b0000000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_BLT   = 2'b11;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID forces a one-cycle hold. A taken-branch flush overrides.
module hazard_detect
    import rv_pkg::*;
(
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_active,
    input  logic                 uses_rs2,
    input  logic                 flush,
    output logic                 stall
);
    logic rs1_hit, rs2_hit;

    assign rs1_hit = (ex_rd == id_rs1);
    assign rs2_hit = uses_rs2 && (ex_rd == id_rs2);
    // x0 is never a real producer, so a load to x0 cannot create a dependency
    assign stall   = ex_mem_read && (ex_rd != '0) && id_active && !flush
                     && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// saturating debug counters for both event types.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_alu_src,
    input  logic                 id_mem_to_reg,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 id_branch,
    input  logic                 id_reg_write,
    input  logic [1:0]           id_alu_op,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [3:0]           id_funct,
    input  logic                 flush,
    output logic                 stall,
    output logic                 ex_alu_src,
    output logic                 ex_mem_to_reg,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_branch,
    output logic                 ex_reg_write,
    output logic [1:0]           ex_alu_op,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [XLEN-1:0]      ex_imm,
    output logic [XLEN-1:0]      ex_pc,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [3:0]           ex_funct,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);
    ctrl_t                ctrl_d, ctrl_q;
    logic [XLEN-1:0]      rs1_data_q, rs2_data_q, imm_q, pc_q;
    logic [REG_IDX_W-1:0] rs1_q, rs2_q, rd_q;
    logic [3:0]           funct_q;
    logic [CNT_W-1:0]     bubble_cnt_q, flush_cnt_q;
    logic                 id_active, uses_rs2, stall_w;

    assign id_active = id_reg_write | id_mem_write | id_branch;
    assign uses_rs2  = ~id_alu_src | id_mem_write;

    // NOPs carry a decoder ALUOp that may be undefined; pin it to ADD
    always_comb begin
        ctrl_d            = '0;
        ctrl_d.alu_src    = id_alu_src;
        ctrl_d.mem_to_reg = id_mem_to_reg;
        ctrl_d.mem_read   = id_mem_read;
        ctrl_d.mem_write  = id_mem_write;
        ctrl_d.branch     = id_branch;
        ctrl_d.reg_write  = id_reg_write;
        ctrl_d.alu_op     = id_active ? id_alu_op : ALU_ADD;
    end

    hazard_detect u_hazard (
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_active   (id_active),
        .uses_rs2    (uses_rs2),
        .flush       (flush),
        .stall       (stall_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            funct_q      <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            // Bubble only clears what EX acts on; operand fields are don't-care
            if (flush || stall_w) begin
                ctrl_q <= '0;
                rd_q   <= '0;
            end else begin
                ctrl_q     <= ctrl_d;
                rs1_data_q <= id_rs1_data;
                rs2_data_q <= id_rs2_data;
                imm_q      <= id_imm;
                pc_q       <= id_pc;
                rs1_q      <= id_rs1;
                rs2_q      <= id_rs2;
                rd_q       <= id_rd;
                funct_q    <= id_funct;
            end
            if (flush && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (stall_w && !(&bubble_cnt_q))
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign stall         = stall_w;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_branch     = ctrl_q.branch;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_rs1_data   = rs1_data_q;
    assign ex_rs2_data   = rs2_data_q;
    assign ex_imm        = imm_q;
    assign ex_pc         = pc_q;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_funct      = funct_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, load-use stalls, flush
// priority, NOP sanitising and counter saturation (small CNT_W).
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_alu_src, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_reg_write;
    logic [1:0]      id_alu_op;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [3:0]      id_funct;
    logic            flush, stall;
    logic            ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_reg_write;
    logic [1:0]      ex_alu_op;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_funct;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch), .id_reg_write(id_reg_write),
        .id_alu_op(id_alu_op), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct(id_funct), .flush(flush), .stall(stall),
        .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_reg_write(ex_reg_write),
        .ex_alu_op(ex_alu_op), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    wire [7:0] ex_ctrl = {ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                          ex_branch, ex_reg_write, ex_alu_op};
    wire [162:0] ex_all = {ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
                           ex_rs1, ex_rs2, ex_rd, ex_funct, bubble_cnt, flush_cnt};

    // Inputs change 1ns after the rising edge; checks happen on the falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm);
        {id_alu_src, id_mem_to_reg, id_mem_read, id_mem_write,
         id_branch, id_reg_write, id_alu_op} = ctrl;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_imm = imm;
        id_rs1_data = 32'h1000_0000 | 32'(rs1);
        id_rs2_data = 32'h2000_0000 | 32'(rs2);
        id_pc = 32'h0000_4000 + 32'(rd) * 4;
        id_funct = 4'h0;
    endtask

    // ctrl = {alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write, alu_op}
    localparam logic [7:0] C_ADDI = 8'b1_0_0_0_0_1_00;
    localparam logic [7:0] C_LW   = 8'b1_1_1_0_0_1_00;
    localparam logic [7:0] C_RTYP = 8'b0_0_0_0_0_1_10;
    localparam logic [7:0] C_SW   = 8'b1_0_0_1_0_0_00;

    task automatic do_reset();
        flush = 1'b0;
        rst_n = 1'b0;
        sample();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        flush = 1'b0;
        {id_alu_src, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_reg_write} = 6'b111111;
        id_alu_op = 2'($urandom); id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_imm = $urandom; id_pc = $urandom; id_rs1 = 5'd3; id_rs2 = 5'd3; id_rd = 5'd3;
        id_funct = 4'($urandom);
        rst_n = 1'b0;
        #2;
        checks++;
        if (ex_all !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", ex_all); end
        step(); sample();
        checks++;
        if (ex_all !== '0 || stall !== 1'b0) begin
            errors++; $display("FAIL reset_held got=%h stall=%b want=0", ex_all, stall);
        end
        rst_n = 1'b1;
        drive(C_ADDI, 5'd1, 5'd0, 5'd5, 32'd7);
        step(); sample();
        checks++;
        if (ex_ctrl !== C_ADDI || ex_rd !== 5'd5 || ex_imm !== 32'd7) begin
            errors++; $display("FAIL addi_capture ctrl=%b rd=%0d imm=%0d want ctrl=%b rd=5 imm=7",
                               ex_ctrl, ex_rd, ex_imm, C_ADDI);
        end
    endtask

    task automatic test_load_use();
        drive(C_LW, 5'd2, 5'd0, 5'd3, 32'd8);
        step();
        drive(C_RTYP, 5'd1, 5'd3, 5'd7, 32'd0);
        sample();
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b want=1", stall); end
        step(); sample();
        checks++;
        if (ex_ctrl !== 8'h00 || ex_rd !== 5'd0) begin
            errors++; $display("FAIL lu_bubble ctrl=%b rd=%0d want 0/0", ex_ctrl, ex_rd);
        end
        checks++;
        if (stall !== 1'b0 || bubble_cnt !== 4'd1) begin
            errors++; $display("FAIL lu_release stall=%b bubble_cnt=%0d want 0/1", stall, bubble_cnt);
        end
        step(); sample();
        checks++;
        if (ex_ctrl !== C_RTYP || ex_rd !== 5'd7 || ex_rs2 !== 5'd3 || ex_rs2_data !== 32'h2000_0003) begin
            errors++; $display("FAIL lu_rtype_capture ctrl=%b rd=%0d rs2=%0d want %b/7/3",
                               ex_ctrl, ex_rd, ex_rs2, C_RTYP);
        end
    endtask

    task automatic test_no_false_hazard();
        drive(C_LW, 5'd1, 5'd0, 5'd0, 32'd0);
        step();
        drive(C_RTYP, 5'd0, 5'd0, 5'd8, 32'd0);
        sample();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL x0_no_stall got=%b want=0", stall); end
        step();
        drive(C_LW, 5'd1, 5'd0, 5'd4, 32'd0);
        step();
        drive(C_ADDI, 5'd2, 5'd4, 5'd9, 32'd1);
        sample();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL addi_rs2_unused got=%b want=0", stall); end
        step();
    endtask

    task automatic test_flush_priority();
        do_reset();
        drive(C_LW, 5'd1, 5'd0, 5'd6, 32'd0);
        step();
        drive(C_SW, 5'd1, 5'd6, 5'd0, 32'd12);
        flush = 1'b1;
        sample();
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b want=0", stall); end
        step();
        flush = 1'b0;
        drive(8'h00, 5'd0, 5'd0, 5'd0, 32'd0);
        sample();
        checks++;
        if (ex_ctrl !== 8'h00 || ex_rd !== 5'd0 || flush_cnt !== 4'd1 || bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL flush_bubble ctrl=%b rd=%0d flush_cnt=%0d bubble_cnt=%0d want 0/0/1/0",
                               ex_ctrl, ex_rd, flush_cnt, bubble_cnt);
        end
    endtask

    task automatic test_nop_sanitise();
        drive(8'h00, 5'd0, 5'd0, 5'd0, 32'd0);
        id_alu_op = 2'bzz;
        step(); sample();
        checks++;
        if (ex_alu_op !== 2'b00 || ex_ctrl !== 8'h00) begin
            errors++; $display("FAIL nop_aluop got=%b ctrl=%b want 00", ex_alu_op, ex_ctrl);
        end
        checks++;
        if ((^ex_all) === 1'bx) begin errors++; $display("FAIL nop_no_x got=%h", ex_all); end
        drive(C_RTYP, 5'd1, 5'd2, 5'd11, 32'd0);
        id_alu_op = 2'b11;
        step(); sample();
        checks++;
        if (ex_alu_op !== 2'b11) begin errors++; $display("FAIL active_aluop got=%b want=11", ex_alu_op); end
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        // LW x3 <- 0(x3) held in ID: capture, stall, capture, stall, ...
        drive(C_LW, 5'd3, 5'd0, 5'd3, 32'd0);
        for (int i = 1; i <= 38; i++) begin
            step();
            if (i == 28) begin
                checks++;
                if (bubble_cnt !== 4'd14) begin
                    errors++; $display("FAIL sat_count_mid got=%0d want=14", bubble_cnt);
                end
            end
        end
        sample();
        checks++;
        if (bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got=%0d want=15", bubble_cnt); end
        step(); sample();
        checks++;
        if (stall !== 1'b1 || ex_mem_read !== 1'b1) begin
            errors++; $display("FAIL pre_reset_stall stall=%b mem_read=%b want 1/1", stall, ex_mem_read);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ex_all !== '0 || stall !== 1'b0) begin
            errors++; $display("FAIL midstall_reset got=%h stall=%b want=0", ex_all, stall);
        end
        sample();
        rst_n = 1'b1;
        step(); sample();
        checks++;
        if (ex_mem_read !== 1'b1 || ex_rd !== 5'd3 || bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL post_reset_capture mem_read=%b rd=%0d bubble_cnt=%0d want 1/3/0",
                               ex_mem_read, ex_rd, bubble_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_flush_priority();
        test_nop_sanitise();
        test_saturation_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
